// File: rtl/multicycle_bus_adapter_pkg.sv
// Shared types and constants for the multicycle bus adapter and its load aligner.
package multicycle_bus_adapter_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  localparam logic [1:0] MEM_SIZE_BYTE    = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF    = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD    = 2'b10;
  localparam int         MEM_UNSIGNED_BIT = 2;

  // Any encoding other than byte/half is treated as a full word access.
  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      MEM_SIZE_BYTE: mem_misaligned = 1'b0;
      MEM_SIZE_HALF: mem_misaligned = offset[0];
      default:       mem_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/multicycle_load_align.sv
// Combinational load extraction: shifts the raw bus word down to the addressed
// byte/half and sign- or zero-extends it. Word accesses pass through untouched.
module multicycle_load_align
  import multicycle_bus_adapter_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic        sign_ext;

  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    sign_ext = ~funct3[MEM_UNSIGNED_BIT];
    case (funct3[1:0])
      MEM_SIZE_BYTE: data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      MEM_SIZE_HALF: data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:       data = rdata;
    endcase
  end

endmodule

// File: rtl/multicycle_bus_adapter.sv
// Turns the multicycle controller's memory strobes into a valid/ready bus access.
// Optional watchdog on stalled accesses: define MC_BUS_TIMEOUT_EN.
module multicycle_bus_adapter
  import multicycle_bus_adapter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_inst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_done,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_enable,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  state_t      state;
  logic [1:0]  lat_offset;
  logic [2:0]  lat_funct3;
  logic [31:0] load_data;

  logic        req_any;
  logic        req_misaligned;
  logic [1:0]  req_size;
  logic [2:0]  req_eff_funct3;
  logic [3:0]  req_be;
  logic [31:0] req_lanes;
  logic        timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
  end

  // Instruction fetches are always word accesses regardless of funct3.
  always_comb begin
    req_any        = req_read | req_write;
    req_size       = req_inst ? MEM_SIZE_WORD : req_funct3[1:0];
    req_eff_funct3 = req_inst ? {1'b0, MEM_SIZE_WORD} : req_funct3;
    req_misaligned = mem_misaligned(req_size, req_addr[1:0]);
    case (req_size)
      MEM_SIZE_BYTE: begin
        req_be    = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      MEM_SIZE_HALF: begin
        req_be    = 4'b0011 << {req_addr[1], 1'b0};
        req_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_lanes = req_wdata;
      end
    endcase
  end

  multicycle_load_align u_load_align (
    .rdata  (bus_rdata),
    .offset (lat_offset),
    .funct3 (lat_funct3),
    .data   (load_data)
  );

`ifdef MC_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wd_cnt;

  // REQ is only entered from IDLE, so clearing while idle clears on entry.
  always_ff @(posedge clock) begin
    if (reset)                                     wd_cnt <= '0;
    else if (state == IDLE)                        wd_cnt <= '0;
    else if (state == REQ || state == WAIT_RESP)   wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      lat_offset      <= '0;
      lat_funct3      <= '0;
      resp_done       <= 1'b0;
      resp_error      <= 1'b0;
      resp_rdata      <= '0;
      busy            <= 1'b0;
      bus_valid       <= 1'b0;
      bus_write       <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      bus_byte_enable <= '0;
    end else begin
      resp_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            lat_offset      <= req_addr[1:0];
            lat_funct3      <= req_eff_funct3;
            bus_write       <= req_write;
            bus_addr        <= {req_addr[31:2], 2'b00};
            bus_wdata       <= req_lanes;
            bus_byte_enable <= req_be;
            busy            <= 1'b1;
            if (req_misaligned) begin
              state      <= DONE;
              resp_done  <= 1'b1;
              resp_error <= 1'b1;
            end else begin
              state     <= REQ;
              bus_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (bus_write) begin
              state      <= DONE;
              resp_done  <= 1'b1;
              resp_error <= 1'b0;
            end else begin
              state <= WAIT_RESP;
            end
          end else if (timeout) begin
            bus_valid  <= 1'b0;
            state      <= DONE;
            resp_done  <= 1'b1;
            resp_error <= 1'b1;
          end
        end
        WAIT_RESP: begin
          if (bus_rvalid) begin
            resp_rdata <= load_data;
            state      <= DONE;
            resp_done  <= 1'b1;
            resp_error <= 1'b0;
          end else if (timeout) begin
            state      <= DONE;
            resp_done  <= 1'b1;
            resp_error <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          resp_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_bus_adapter.sv
// Directed, table-driven bench for multicycle_bus_adapter with a cycle-accurate bus responder.
module tb_multicycle_bus_adapter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_read, req_write, req_inst;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_done, resp_error, busy;
  logic [31:0] resp_rdata;
  logic        bus_valid, bus_ready, bus_write, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byte_enable;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  multicycle_bus_adapter #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_inst(req_inst),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_done(resp_done), .resp_error(resp_error), .resp_rdata(resp_rdata), .busy(busy),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byte_enable(bus_byte_enable),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        rd, wr, inst;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    int          rdy_dly, rv_dly;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    all_outs = {23'd0, resp_done, resp_error, resp_rdata, busy, bus_valid, bus_write,
                bus_addr, bus_wdata, bus_byte_enable};
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    int cyc, first_v, hs, done_c;
    logic err, stable_bad;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_wr;
    v = vecs[i];
    @(negedge clock);
    req_read = v.rd; req_write = v.wr; req_inst = v.inst;
    req_addr = v.addr; req_wdata = v.wdata; req_funct3 = v.f3;
    @(posedge clock); #1;
    req_read = 1'b0; req_write = 1'b0;
    cyc = 1; first_v = -1; hs = -1; done_c = -1; err = 1'bx; stable_bad = 1'b0;
    cap_addr = '0; cap_wd = '0; cap_be = '0; cap_wr = 1'b0;
    while (cyc < 60) begin
      if (resp_done) begin
        done_c = cyc; err = resp_error;
        break;
      end
      if (bus_valid) begin
        if (first_v < 0) begin
          first_v = cyc; cap_addr = bus_addr; cap_be = bus_byte_enable;
          cap_wd = bus_wdata; cap_wr = bus_write;
        end else if (bus_addr !== cap_addr || bus_byte_enable !== cap_be ||
                     bus_wdata !== cap_wd || bus_write !== cap_wr) begin
          stable_bad = 1'b1;
        end
        bus_ready = (cyc - first_v >= v.rdy_dly);
      end else begin
        bus_ready = 1'b0;
      end
      // Stray rvalid during a REQ stall must be ignored by the adapter.
      if (hs >= 0 && cyc == hs + v.rv_dly) begin
        bus_rvalid = 1'b1; bus_rdata = v.rdata;
      end else if (bus_valid && !bus_ready) begin
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_0000;
      end else begin
        bus_rvalid = 1'b0; bus_rdata = 32'h0BAD_F00D;
      end
      if (bus_valid && bus_ready) hs = cyc;
      @(posedge clock); #1;
      cyc++;
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    chk($sformatf("v%0d done_cycle", i), done_c, v.exp_done);
    chk($sformatf("v%0d error", i), err, v.exp_err);
    chk($sformatf("v%0d rdata", i), resp_rdata, v.exp_rdata);
    if (v.exp_done == 1) begin
      chk($sformatf("v%0d no_valid", i), first_v, -1);
    end else begin
      chk($sformatf("v%0d valid_cycle", i), first_v, 1);
      chk($sformatf("v%0d addr", i), cap_addr, v.exp_addr);
      chk($sformatf("v%0d be", i), cap_be, v.exp_be);
      chk($sformatf("v%0d write", i), cap_wr, v.wr);
      chk($sformatf("v%0d stable", i), stable_bad, 1'b0);
      if (v.wr) chk($sformatf("v%0d wdata", i), cap_wd, v.exp_wdata);
    end
    @(posedge clock); #1;
    chk($sformatf("v%0d done_pulse_len", i), {resp_done, busy}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int cyc, vcnt, done_c;
    logic err, saw_done;
    // rd wr inst addr wdata f3 rdy rv rdata | be addr wdata rdata err done
    vecs[0]  = '{0,1,0,32'h100,32'hDEADBEEF,3'b010,0,1,32'h0,        4'hF,32'h100,32'hDEADBEEF,32'h0,       0,2};
    vecs[1]  = '{1,0,0,32'h203,32'h0,      3'b000,2,3,32'h80FF1234, 4'h8,32'h200,32'h0,       32'hFFFFFF80,0,7};
    vecs[2]  = '{1,0,0,32'h302,32'h0,      3'b101,0,1,32'h9ABC0000, 4'hC,32'h300,32'h0,       32'h00009ABC,0,3};
    vecs[3]  = '{0,1,0,32'h001,32'h55,     3'b000,0,1,32'h0,        4'h2,32'h000,32'h55555555,32'h00009ABC,0,2};
    vecs[4]  = '{1,0,0,32'h102,32'h0,      3'b010,0,1,32'h0,        4'h0,32'h0,  32'h0,       32'h00009ABC,1,1};
    vecs[5]  = '{1,0,0,32'h002,32'h0,      3'b001,1,2,32'h80017FFF, 4'hC,32'h000,32'h0,       32'hFFFF8001,0,5};
    vecs[6]  = '{1,0,0,32'h001,32'h0,      3'b100,0,1,32'h0000F000, 4'h2,32'h000,32'h0,       32'h000000F0,0,3};
    vecs[7]  = '{0,1,0,32'h006,32'h1234ABCD,3'b001,3,1,32'h0,       4'hC,32'h004,32'hABCDABCD,32'h000000F0,0,5};
    vecs[8]  = '{0,1,0,32'h005,32'h1234ABCD,3'b001,0,1,32'h0,       4'h0,32'h0,  32'h0,       32'h000000F0,1,1};
    vecs[9]  = '{1,0,1,32'h040,32'h0,      3'b000,0,1,32'h12345678, 4'hF,32'h040,32'h0,       32'h12345678,0,3};
    vecs[10] = '{1,0,1,32'h041,32'h0,      3'b000,0,1,32'h0,        4'h0,32'h0,  32'h0,       32'h12345678,1,1};
    vecs[11] = '{1,1,0,32'h008,32'hCAFEF00D,3'b010,1,1,32'h0,       4'hF,32'h008,32'hCAFEF00D,32'h12345678,0,3};
    vecs[12] = '{1,0,0,32'h000,32'h0,      3'b000,0,1,32'h0000007F, 4'h1,32'h000,32'h0,       32'h0000007F,0,3};

    reset = 1'b1; req_read = 0; req_write = 0; req_inst = 0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", all_outs(), '0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Long stall on bus_ready: watchdog fires when compiled in, otherwise waits.
    @(negedge clock);
    req_read = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_inst = 1'b0;
    @(posedge clock); #1;
    req_read = 1'b0;
    cyc = 1; vcnt = 0; done_c = -1; err = 1'bx;
`ifdef MC_BUS_TIMEOUT_EN
    while (cyc < 40) begin
      if (resp_done) begin done_c = cyc; err = resp_error; break; end
      if (bus_valid) vcnt++;
      @(posedge clock); #1; cyc++;
    end
    chk("timeout done_cycle", done_c, 9);
    chk("timeout error", err, 1'b1);
    chk("timeout valid_cycles", vcnt, 8);
    chk("timeout valid_dropped", bus_valid, 1'b0);
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
      @(posedge clock); #1;
      saw_done |= resp_done;
    end
    bus_rvalid = 1'b0;
    chk("timeout late_rvalid_done", saw_done, 1'b0);
    chk("timeout late_rvalid_rdata", resp_rdata, 32'h0000007F);
`else
    while (cyc < 20) begin
      if (bus_valid) vcnt++;
      if (resp_done) done_c = cyc;
      @(posedge clock); #1; cyc++;
    end
    chk("stall no_done", done_c, -1);
    chk("stall valid_held", vcnt, 19);
    bus_ready = 1'b1;
    @(posedge clock); #1;
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hA5A5_5A5A;
    @(posedge clock); #1;
    bus_rvalid = 1'b0;
    chk("stall done", {resp_done, resp_error}, 2'b10);
    chk("stall rdata", resp_rdata, 32'hA5A5_5A5A);
    @(posedge clock); #1;
`endif

    // Reset while waiting for read data, then stray rvalid afterwards.
    @(negedge clock);
    req_read = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010;
    @(posedge clock); #1;
    req_read = 1'b0; bus_ready = 1'b1;
    @(posedge clock); #1;
    bus_ready = 1'b0;
    chk("rst_mid in_wait", {bus_valid, busy, resp_done}, 3'b010);
    reset = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    @(posedge clock); #1;
    chk("rst_mid outputs", all_outs(), '0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      saw_done |= resp_done;
    end
    bus_rvalid = 1'b0;
    chk("rst_mid no_done", saw_done, 1'b0);
    chk("rst_mid idle_outputs", all_outs(), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
